pe_operand_loader: RTL

Upstream feeder for the 49-lane FP16 MAC array and adder tree. Accepts operand pairs one per cycle over a valid/ready stream, assembles them into 49-lane tiles in two ping-pong banks, and issues each full tile to the MAC array for exactly one cycle. Drives zeros on every other cycle so the always-accumulating MACs are not disturbed. Sequences accumulation groups: it flags when the final sum is valid and pulses an accumulator clear before the next group starts.

---
 rtl/pe_operand_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pe_operand_loader.sv
// pe_operand_loader: ping-pong tile loader and accumulation-group sequencer for the FP16 MAC array.
// Optional Inf/NaN scrubbing of incoming operands is enabled by defining PE_LOADER_FP16_SANITIZE_EN.
module pe_operand_loader #(
  parameter int LANES           = 49,
  parameter int TILES_PER_GROUP = 4,
  parameter int PIPE_LATENCY    = 7
) (
  input  logic                clk,
  input  logic                rst,
  // Stream: a pair transfers on a rising edge where in_valid && in_ready; in_ready depends only
  // on registered bank state (never on in_valid), and the source holds its data until accepted.
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_a,
  input  logic [15:0]         in_b,
  output logic [16*LANES-1:0] A_inputs,
  output logic [16*LANES-1:0] B_inputs,
  output logic                acc_clr,
  output logic                result_valid,
  output logic                busy,
  output logic                bad_operand,
  output logic [1:0]          fsm_state
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LW = $clog2(PIPE_LATENCY + 1) + 1;
  localparam int TW = 8;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  logic [15:0]         mem_a [2][LANES];
  logic [15:0]         mem_b [2][LANES];
  logic [1:0]          bank_full;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [IW-1:0]       wr_idx;
  state_t              state;
  logic [TW-1:0]       tcnt;
  logic [LW-1:0]       lat_cnt;

  logic                hs;
  logic                fill_now;
  logic                bypass;
  logic                issue_go;
  logic [15:0]         san_a;
  logic [15:0]         san_b;
  logic [16*LANES-1:0] tile_a;
  logic [16*LANES-1:0] tile_b;

`ifdef PE_LOADER_FP16_SANITIZE_EN
  logic bad_now;

  assign san_a   = (in_a[14:10] == 5'h1F) ? 16'h0000 : in_a;
  assign san_b   = (in_b[14:10] == 5'h1F) ? 16'h0000 : in_b;
  assign bad_now = hs && ((in_a[14:10] == 5'h1F) || (in_b[14:10] == 5'h1F));

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_operand <= 1'b0;
    end else if (bad_now) begin
      bad_operand <= 1'b1;
    end
  end
`else
  assign san_a       = in_a;
  assign san_b       = in_b;
  assign bad_operand = 1'b0;
`endif

  assign in_ready = !bank_full[wr_ptr];
  assign hs       = in_valid && in_ready;
  assign fill_now = hs && (wr_idx == IW'(LANES - 1));

  // Completing the bank that is next to issue lets the tile go out on the same edge, taking the
  // final lane straight from the input so the issue cycle follows the last accept directly.
  assign bypass   = fill_now && (wr_ptr == rd_ptr);
  assign issue_go = (state != ST_DRAIN) && (bank_full[rd_ptr] || bypass);

  assign busy      = (|bank_full) || (tcnt != '0) || (state != ST_ISSUE);
  assign fsm_state = state;

  always_comb begin
    tile_a = '0;
    tile_b = '0;
    for (int i = 0; i < LANES; i++) begin
      tile_a[16*i +: 16] = mem_a[rd_ptr][i];
      tile_b[16*i +: 16] = mem_b[rd_ptr][i];
    end
    if (bypass) begin
      tile_a[16*(LANES-1) +: 16] = san_a;
      tile_b[16*(LANES-1) +: 16] = san_b;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      mem_a[wr_ptr][wr_idx] <= san_a;
      mem_b[wr_ptr][wr_idx] <= san_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_idx       <= '0;
      state        <= ST_ISSUE;
      tcnt         <= '0;
      lat_cnt      <= '0;
      A_inputs     <= '0;
      B_inputs     <= '0;
      acc_clr      <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      acc_clr      <= 1'b0;
      result_valid <= 1'b0;
      A_inputs     <= '0;
      B_inputs     <= '0;

      if (hs) begin
        if (fill_now) begin
          bank_full[wr_ptr] <= 1'b1;
          wr_ptr            <= ~wr_ptr;
          wr_idx            <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end

      // The clear of the issued bank is written after the fill so a bypassed bank ends up empty.
      if (issue_go) begin
        A_inputs          <= tile_a;
        B_inputs          <= tile_b;
        bank_full[rd_ptr] <= 1'b0;
        rd_ptr            <= ~rd_ptr;
        if (tcnt == TW'(TILES_PER_GROUP - 1)) begin
          tcnt    <= '0;
          lat_cnt <= '0;
          state   <= ST_DRAIN;
        end else begin
          tcnt  <= tcnt + 1'b1;
          state <= ST_ISSUE;
        end
      end else begin
        case (state)
          ST_DRAIN: begin
            lat_cnt <= lat_cnt + 1'b1;
            if (lat_cnt == LW'(PIPE_LATENCY - 1)) begin
              result_valid <= 1'b1;
            end
            if (lat_cnt == LW'(PIPE_LATENCY)) begin
              acc_clr <= 1'b1;
              state   <= ST_CLEAR;
            end
          end
          ST_CLEAR: state <= ST_ISSUE;
          default:  state <= ST_ISSUE;
        endcase
      end
    end
  end

endmodule
